winograd_ewmac_output_transform: RTL and testbench

- Stage directly downstream of filter_3x3_transform in the Winograd F(2x2,3x3) datapath.
- Per input channel, multiplies the 4x4 transformed filter tile U elementwise with the 4x4 transformed input tile V and accumulates over channels into M.
- On the last channel, applies the output transform Y = A^T M A and presents the 2x2 output tile.
- Valid/ready on both sides; one tile in flight.

---
 rtl/winograd_ewmac_output_transform.sv | 155 +++++++++++++++
 tb/tb_winograd_ewmac_output_transform.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_ewmac_output_transform.sv
// Winograd F(2x2,3x3) elementwise multiply-accumulate and output transform.
// Each accepted beat multiplies U and V element-by-element and accumulates
// the products over input channels. After the last channel, Y = A^T M A is
// computed in a single cycle, and the 2x2 tile is held until the consumer
// accepts it.
// Optional build macro: OUT_RELU_EN clamps negative output elements to zero.
module winograd_ewmac_output_transform #(
    parameter int W     = 8,
    parameter int DW    = 10,
    parameter int ACC_W = 24,
    parameter int OW    = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [16*W-1:0]   filter_transformed,
    input  logic [16*DW-1:0]  input_transformed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*OW-1:0]   out_tile,
    output logic [15:0]       tile_cnt
);

    localparam int PW = W + DW;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        XFORM,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q [16];
    logic [ACC_W-1:0]   acc_d [16];
    logic [ACC_W-1:0]   prod_ext [16];
    logic [OW-1:0]      mx [16];
    logic [OW-1:0]      t_row [4];
    logic [OW-1:0]      y00, y01, y10, y11;
    logic [4*OW-1:0]    y_tile;
    logic               out_valid_q, out_valid_d;
    logic [4*OW-1:0]    out_tile_q, out_tile_d;
    logic [15:0]        tile_cnt_q, tile_cnt_d;
    logic               beat;

    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign beat      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_tile  = out_tile_q;
    assign tile_cnt  = tile_cnt_q;

    // Full-width signed elementwise products, sign-extended to accumulator width.
    always_comb begin
        logic signed [W-1:0]  u;
        logic signed [DW-1:0] v;
        logic signed [PW-1:0] p;
        for (int unsigned i = 0; i < 16; i++) begin
            u = filter_transformed[i*W +: W];
            v = input_transformed[i*DW +: DW];
            p = u * v;
            prod_ext[i] = {{(ACC_W-PW){p[PW-1]}}, p};
        end
    end

    // Output transform Y = A^T M A on sign-extended accumulators.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            mx[i] = {{(OW-ACC_W){acc_q[i][ACC_W-1]}}, acc_q[i]};
        end
        for (int unsigned r = 0; r < 4; r++) begin
            t_row[r] = mx[r*4+1] - mx[r*4+2] - mx[r*4+3];
        end
        y00 = '0;
        y10 = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                y00 = y00 + mx[r*4+c];
            end
        end
        for (int unsigned c = 0; c < 3; c++) begin
            y10 = y10 + mx[4+c] - mx[8+c] - mx[12+c];
        end
        y01 = t_row[0] + t_row[1] + t_row[2];
        y11 = t_row[1] - t_row[2] - t_row[3];
`ifdef OUT_RELU_EN
        if (y00[OW-1]) y00 = '0;
        if (y01[OW-1]) y01 = '0;
        if (y10[OW-1]) y10 = '0;
        if (y11[OW-1]) y11 = '0;
`endif
        y_tile = {y11, y10, y01, y00};
    end

    // Next-state, accumulator and output-register update logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_tile_d  = out_tile_q;
        tile_cnt_d  = tile_cnt_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        acc_d[i] = prod_ext[i];
                    end
                    state_d = in_last ? XFORM : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        acc_d[i] = acc_q[i] + prod_ext[i];
                    end
                    if (in_last) begin
                        state_d = XFORM;
                    end
                end
            end
            XFORM: begin
                out_tile_d  = y_tile;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    tile_cnt_d  = tile_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_tile_q  <= '0;
            tile_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_tile_q  <= out_tile_d;
            tile_cnt_q  <= tile_cnt_d;
        end
    end

endmodule

// File: tb/tb_winograd_ewmac_output_transform.sv
// Scoreboard bench for winograd_ewmac_output_transform.
// The stimulus side pushes expected tiles computed as A^T M A from a
// matrix-level reference model. The monitor compares every presented tile.
module tb_winograd_ewmac_output_transform;

    localparam int W     = 8;
    localparam int DW    = 10;
    localparam int ACC_W = 24;
    localparam int OW    = 28;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [16*W-1:0]   filter_transformed;
    logic [16*DW-1:0]  input_transformed;
    logic              out_valid;
    logic              out_ready;
    logic [4*OW-1:0]   out_tile;
    logic [15:0]       tile_cnt;

    winograd_ewmac_output_transform #(
        .W     (W),
        .DW    (DW),
        .ACC_W (ACC_W),
        .OW    (OW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_last            (in_last),
        .filter_transformed (filter_transformed),
        .input_transformed  (input_transformed),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_tile           (out_tile),
        .tile_cnt           (tile_cnt)
    );

    int                nchk = 0;
    int                nfail = 0;
    logic [4*OW-1:0]   sb[$];
    int                ub[16];
    int                vb[16];
    longint            macc[16];
    bit                fresh = 1'b1;
    bit                bp_hold = 1'b1;
    logic [15:0]       exp_cnt = '0;
    bit                cnt_pending = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint wrap_acc(input longint x);
        longint t;
        t = x & 64'hFFFFFF;
        if (t >= 64'h800000) t = t - 64'h1000000;
        return t;
    endfunction

    // Y = A^T M A with A = [1 0; 1 1; 1 -1; 0 -1].
    function automatic logic [4*OW-1:0] model_tile();
        longint a[4][2];
        longint y;
        logic [4*OW-1:0] res;
        a[0][0] = 1; a[0][1] = 0;
        a[1][0] = 1; a[1][1] = 1;
        a[2][0] = 1; a[2][1] = -1;
        a[3][0] = 0; a[3][1] = -1;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                y = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        y = y + a[r][i] * macc[r*4+c] * a[c][j];
`ifdef OUT_RELU_EN
                if (y < 0) y = 0;
`endif
                res[(i*2+j)*OW +: OW] = OW'(y);
            end
        end
        return res;
    endfunction

    task automatic set_all(input int u, input int v);
        for (int i = 0; i < 16; i++) begin
            ub[i] = u;
            vb[i] = v;
        end
    endtask

    task automatic set_rand();
        logic signed [W-1:0]  r8;
        logic signed [DW-1:0] r10;
        for (int i = 0; i < 16; i++) begin
            r8  = W'($urandom);
            r10 = DW'($urandom);
            if ($urandom_range(0, 7) == 0) r8 = (r8[0]) ? -8'sd128 : 8'sd127;
            if ($urandom_range(0, 7) == 0) r10 = (r10[0]) ? -10'sd512 : 10'sd511;
            ub[i] = int'(r8);
            vb[i] = int'(r10);
        end
    endtask

    // Issued from posedge+#1; waits a bounded number of cycles for acceptance.
    task automatic send_beat(input bit last);
        bit acc_ok;
        for (int i = 0; i < 16; i++) begin
            filter_transformed[i*W +: W]  = W'(ub[i]);
            input_transformed[i*DW +: DW] = DW'(vb[i]);
        end
        in_valid = 1'b1;
        in_last  = last;
        acc_ok   = 1'b0;
        for (int n = 0; n < 300 && !acc_ok; n++) begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        if (!acc_ok) begin
            check(1'b0, "beat_accept_timeout", 128'(0), 128'(1));
        end else begin
            for (int i = 0; i < 16; i++) begin
                macc[i] = wrap_acc((fresh ? 64'sd0 : macc[i]) + longint'(ub[i]) * longint'(vb[i]));
            end
            fresh = 1'b0;
            if (last) begin
                sb.push_back(model_tile());
                fresh = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || cnt_pending) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || cnt_pending) check(1'b0, "drain_timeout", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Consumer: random acceptance unless backpressure is forced.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare the presented tile to the scoreboard head every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cnt_pending) begin
                    check(tile_cnt == exp_cnt, "tile_cnt", 128'(tile_cnt), 128'(exp_cnt));
                    check(in_ready == 1'b1, "in_ready_after_hs", 128'(in_ready), 128'(1));
                    cnt_pending = 1'b0;
                end
                if (out_valid) begin
                    check(in_ready == 1'b0, "in_ready_in_out", 128'(in_ready), 128'(0));
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_tile", 128'(out_tile), 128'(0));
                    end else begin
                        check(out_tile == sb[0], "out_tile", 128'(out_tile), 128'(sb[0]));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            exp_cnt = exp_cnt + 16'd1;
                            cnt_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int wait_n;
        int nch;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        filter_transformed = '0;
        input_transformed = '0;
        for (int i = 0; i < 16; i++) macc[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(in_ready == 1'b1, "rst_in_ready", 128'(in_ready), 128'(1));
        check(out_valid == 1'b0, "rst_out_valid", 128'(out_valid), 128'(0));
        check(out_tile == '0, "rst_out_tile", 128'(out_tile), 128'(0));
        check(tile_cnt == 16'd0, "rst_tile_cnt", 128'(tile_cnt), 128'(0));
        @(posedge clk);
        #1;
        bp_hold = 1'b0;

        set_all(1, 1);
        send_beat(1'b1);
        drain();

        set_all(1, 1);
        send_beat(1'b0);
        send_beat(1'b1);
        drain();

        set_all(-128, -512);
        send_beat(1'b1);
        drain();

        bp_hold = 1'b1;
        @(posedge clk);
        #1;
        set_all(1, 1);
        send_beat(1'b1);
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        check(out_valid == 1'b1, "bp_out_valid_timeout", 128'(out_valid), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        set_rand();
        fork
            send_beat(1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                bp_hold = 1'b0;
            end
        join
        drain();

        for (int t = 0; t < 30; t++) begin
            nch = $urandom_range(1, 4);
            for (int c = 0; c < nch; c++) begin
                set_rand();
                send_beat(c == nch - 1);
            end
        end
        drain();

        set_rand();
        send_beat(1'b0);
        set_rand();
        send_beat(1'b0);
        rst = 1'b1;
        fresh = 1'b1;
        exp_cnt = '0;
        cnt_pending = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "midrst_out_valid", 128'(out_valid), 128'(0));
        check(in_ready == 1'b1, "midrst_in_ready", 128'(in_ready), 128'(1));
        check(tile_cnt == 16'd0, "midrst_tile_cnt", 128'(tile_cnt), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_all(1, 1);
        send_beat(1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
